// File: rtl/fifo_rd_stream_if.sv
// Bundle of the FIFO read-port signals and the downstream valid/ready stream
// around fifo_rd_stream; the master modport is the drain stage's own view.
interface fifo_rd_stream_if #(
    parameter int data_width = 8,
    parameter int CNT_W      = 16
);
    logic                  empty;
    logic                  rd_en;
    logic [data_width-1:0] data_out;
    logic                  out_valid;
    logic                  out_ready;
    logic [data_width-1:0] out_data;
    logic [CNT_W-1:0]      word_cnt;

    modport master (
        input  empty,
        input  data_out,
        input  out_ready,
        output rd_en,
        output out_valid,
        output out_data,
        output word_cnt
    );

    modport slave (
        output empty,
        output data_out,
        output out_ready,
        input  rd_en,
        input  out_valid,
        input  out_data,
        input  word_cnt
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage: pops the async FIFO, hides its 1-cycle read latency in a
// 2-entry buffer and emits a valid/ready stream. FIFO_RD_STREAM_CNT_EN enables word_cnt.
module fifo_rd_stream #(
    parameter int data_width = 8,
    parameter int CNT_W      = 16
) (
    input  logic           rd_clk,
    input  logic           rst,
    fifo_rd_stream_if.master bus
);

    logic                  r_inflight;
    logic [1:0]            r_count;
    logic                  r_head;
    logic                  r_tail;
    logic [data_width-1:0] r_mem [2];

    logic                  w_out_valid;
    logic                  w_pop;
    logic [1:0]            w_count_next;

    assign w_out_valid  = (r_count != 2'd0);
    assign w_pop        = w_out_valid && bus.out_ready;
    // Occupancy after this edge counting the word already in flight from the FIFO.
    assign w_count_next = r_count + {1'b0, r_inflight} - {1'b0, w_pop};

    assign bus.rd_en     = !rst && !bus.empty && (w_count_next < 2'd2);
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_mem[r_head];

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values; the two buffer entries are reset too, because
    // out_data is read straight from the head entry and must be 0 in reset.
    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_count    <= 2'd0;
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
        end else begin
            r_inflight <= bus.rd_en;
            r_count    <= w_count_next;
            if (w_pop) begin
                r_head <= ~r_head;
            end
            if (r_inflight) begin
                r_mem[r_tail] <= bus.data_out;
                r_tail        <= ~r_tail;
            end
        end
    end

`ifdef FIFO_RD_STREAM_CNT_EN
    logic [CNT_W-1:0] r_word_cnt;

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            r_word_cnt <= '0;
        end else if (w_pop) begin
            r_word_cnt <= r_word_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.word_cnt = r_word_cnt;
`else
    assign bus.word_cnt = '0;
`endif

    a_occupancy: assert property (@(posedge rd_clk) disable iff (rst)
        ({1'b0, r_count} + {2'b00, r_inflight}) <= 3'd2);

    a_no_underflow: assert property (@(posedge rd_clk) disable iff (rst)
        bus.rd_en |-> !bus.empty);

    a_hold_stable: assert property (@(posedge rd_clk) disable iff (rst)
        (w_out_valid && !bus.out_ready) |=> (w_out_valid && $stable(bus.out_data)));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: a queue models the FIFO read port,
// a second queue is the scoreboard; inputs change and outputs are sampled on negedge.
module tb_fifo_rd_stream;

    localparam int DW = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fifo_rd_stream_if #(.data_width(DW), .CNT_W(CW)) bus ();

    fifo_rd_stream #(.data_width(DW), .CNT_W(CW)) dut (
        .rd_clk (clk),
        .rst    (rst),
        .bus    (bus.master)
    );

    typedef struct {
        int   n_words;
        logic ready;
        int   cycles;
        int   exp_rden;
        int   exp_pops;
        int   exp_left;
        logic exp_valid_end;
    } vec_t;

    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] exp_q  [$];
    logic          pending;
    logic [CW-1:0] exp_cnt;
    int            n_rden;
    int            n_pops;
    int            n_checks;
    int            n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [CW-1:0] exp_word_cnt();
`ifdef FIFO_RD_STREAM_CNT_EN
        return exp_cnt;
`else
        return '0;
`endif
    endfunction

    task automatic load(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic clear_model();
        fifo_q.delete();
        exp_q.delete();
        pending = 1'b0;
        exp_cnt = '0;
        n_rden  = 0;
        n_pops  = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.empty     = 1'b1;
        bus.out_ready = 1'b0;
        bus.data_out  = '0;
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One rd_clk cycle: apply FIFO read data for last cycle's pop, drive inputs, sample.
    task automatic cycle(input logic ready);
        @(negedge clk);
        if (pending) begin
            bus.data_out = fifo_q.pop_front();
        end
        bus.empty     = (fifo_q.size() == 0);
        bus.out_ready = ready;
        #1;
        pending = bus.rd_en;
        if (bus.rd_en) begin
            n_rden++;
            if (fifo_q.size() == 0) begin
                check("rd_en_while_empty", 32'd1, 32'd0);
                pending = 1'b0;
            end
        end
        if (bus.out_valid && ready) begin
            n_pops++;
            exp_cnt = exp_cnt + 1'b1;
            if (exp_q.size() == 0) begin
                check("spurious_word", 32'd1, 32'd0);
            end else begin
                check("stream_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
            end
        end
    endtask

    vec_t vecs [6];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clear_model();

        // Reset state: FIFO claims data but rst must keep everything quiet.
        rst           = 1'b1;
        bus.empty     = 1'b0;
        bus.out_ready = 1'b1;
        bus.data_out  = 8'h77;
        @(negedge clk);
        #1;
        check("reset_rd_en",     32'(bus.rd_en),     32'd0);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_out_data",  32'(bus.out_data),  32'd0);
        check("reset_word_cnt",  32'(bus.word_cnt),  32'd0);

        vecs[0] = '{3,  1'b1, 10, 3,  3,  0,  1'b0};  // stream order AA BB CC
        vecs[1] = '{16, 1'b0, 20, 2,  0,  14, 1'b1};  // backpressure
        vecs[2] = '{16, 1'b1, 25, 16, 16, 0,  1'b0};  // full throughput
        vecs[3] = '{0,  1'b1, 50, 0,  0,  0,  1'b0};  // empty FIFO
        vecs[4] = '{1,  1'b0, 10, 1,  0,  0,  1'b1};  // single word held
        vecs[5] = '{2,  1'b1, 3,  2,  1,  0,  1'b1};  // short window

        for (int v = 0; v < 6; v++) begin
            do_reset();
            for (int i = 0; i < vecs[v].n_words; i++) begin
                load(8'hAA + 8'(i * 17));
            end
            for (int c = 0; c < vecs[v].cycles; c++) begin
                cycle(vecs[v].ready);
            end
            check($sformatf("vec%0d_rd_en_pulses", v), 32'(n_rden), 32'(vecs[v].exp_rden));
            check($sformatf("vec%0d_pops", v), 32'(n_pops), 32'(vecs[v].exp_pops));
            check($sformatf("vec%0d_fifo_left", v),
                  32'(fifo_q.size() - (pending ? 1 : 0)), 32'(vecs[v].exp_left));
            check($sformatf("vec%0d_valid_end", v), 32'(bus.out_valid), 32'(vecs[v].exp_valid_end));
        end

        // Latency and no bubbles at full rate.
        begin
            int first;
            int last;
            int n_valid;
            int bubbles;
            do_reset();
            for (int i = 0; i < 16; i++) load(8'h10 + 8'(i));
            first = -1; last = -1; n_valid = 0; bubbles = 0;
            for (int i = 0; i < 40; i++) begin
                cycle(1'b1);
                if (bus.out_valid) begin
                    if (first < 0) first = i;
                    if (last >= 0 && i != last + 1) bubbles++;
                    last = i;
                    n_valid++;
                end
            end
            check("tput_first_valid_cycle", 32'(first), 32'd2);
            check("tput_bubbles", 32'(bubbles), 32'd0);
            check("tput_valid_cycles", 32'(n_valid), 32'd16);
            check("tput_rd_en_idle", 32'(bus.rd_en), 32'd0);
        end

        // Backpressure: head word stays put, then ready rises with count = 2.
        begin
            int unstable;
            do_reset();
            for (int i = 0; i < 16; i++) load(8'h40 + 8'(i));
            unstable = 0;
            for (int i = 0; i < 20; i++) begin
                cycle(1'b0);
                if (bus.out_valid && bus.out_data !== 8'h40) unstable++;
            end
            check("bp_unstable_cycles", 32'(unstable), 32'd0);
            check("bp_head_word", 32'(bus.out_data), 32'h40);
            check("bp_rd_en_pulses", 32'(n_rden), 32'd2);
            check("bp_fifo_left", 32'(fifo_q.size()), 32'd14);
            cycle(1'b1);
            check("bp_rise_rd_en", 32'(bus.rd_en), 32'd1);
            check("bp_rise_pop", 32'(n_pops), 32'd1);
            for (int i = 0; i < 30; i++) cycle(1'b1);
            check("bp_drained_pops", 32'(n_pops), 32'd16);
            check("bp_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        end

        // Counter wrap: 17 pops on a 4-bit counter.
        do_reset();
        for (int i = 0; i < 17; i++) load(8'hC0 + 8'(i));
        for (int i = 0; i < 30; i++) cycle(1'b1);
        cycle(1'b0);
        check("cnt_pops", 32'(n_pops), 32'd17);
`ifdef FIFO_RD_STREAM_CNT_EN
        check("cnt_wrap", 32'(bus.word_cnt), 32'd1);
`else
        check("cnt_wrap", 32'(bus.word_cnt), 32'd0);
`endif

        // Reset while count = 2: outputs clear at once, next word flows normally.
        do_reset();
        for (int i = 0; i < 10; i++) load(8'h80 + 8'(i));
        for (int i = 0; i < 3; i++) cycle(1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0);
        check("mid_pre_valid", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_word_cnt",  32'(bus.word_cnt),  32'd0);
        check("mid_rst_rd_en",     32'(bus.rd_en),     32'd0);
        check("mid_rst_out_data",  32'(bus.out_data),  32'd0);
        bus.empty = 1'b1;
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        load(8'h5A);
        load(8'h5B);
        for (int i = 0; i < 8; i++) cycle(1'b1);
        check("mid_post_pops", 32'(n_pops), 32'd2);
        check("mid_post_word_cnt", 32'(bus.word_cnt), 32'(exp_word_cnt()));

        // Random ready with 100 random words trickling in.
        begin
            int loaded;
            do_reset();
            loaded = 0;
            for (int i = 0; i < 3000 && n_pops < 100; i++) begin
                if (loaded < 100 && $urandom_range(0, 1) == 1) begin
                    load(8'($urandom));
                    loaded++;
                end
                cycle(1'($urandom_range(0, 1)));
            end
            cycle(1'b0);
            check("rand_pops", 32'(n_pops), 32'd100);
            check("rand_scoreboard_empty", 32'(exp_q.size()), 32'd0);
            check("rand_word_cnt", 32'(bus.word_cnt), 32'(exp_word_cnt()));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
